psm_deadtime_nch: RTL
=====================

Name: psm_deadtime_nch

Overview:
- Multi-channel complementary gate-signal generator with dead-time insertion, successor to the single-channel 8-bit dead-time block.
- Each of N_CH PWM/PSM inputs drives a high/low output pair with a per-channel programmable dead time, plus global enable and latched fault shutdown.
- Sits between the modulator/phase-shift generator and the gate-driver pins.

Parameters:
- N_CH, 3, number of independent channels (bridge legs).
- BITS_DATA, 8, dead-time counter width; dead time range 0..2^BITS_DATA-1 cycles.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- iEN  in  1  global enable; low forces all outputs low
- iPSM  in  N_CH  modulator command per channel; 1 = high side, 0 = low side
- iDT  in  N_CH*BITS_DATA  dead time per channel (ch k at [k*BITS_DATA +: BITS_DATA]); used for high-side turn-on, and for both sides when PSM_ASYM_DT_EN is undefined
- iDT_LO  in  N_CH*BITS_DATA  low-side turn-on dead time per channel; ignored when PSM_ASYM_DT_EN is undefined
- iFAULT  in  1  external fault, level-sensitive
- iFAULT_CLR  in  1  one-cycle pulse that clears the fault latch
- oPSM  out  2*N_CH  gate outputs; bit 2k = high side of ch k, bit 2k+1 = low side of ch k
- oFAULT  out  1  fault latch state

Behaviour:
- Reset: oPSM = 0, oFAULT = 0, all channel FSMs in OFF, counters 0, input registers 0.
- Input stage: iPSM is registered once (psm_r). All timing is referenced to the psm_r change edge (E).
- Per-channel FSM states: OFF, DT_HI, ON_HI, DT_LO, ON_LO.
  - OFF: both outputs low, cnt = 0. When run = iEN & !oFAULT is 1, go to DT_HI if psm_r = 1, else DT_LO.
  - DT_HI: both outputs low. cnt increments each cycle, saturating at all-ones. When cnt >= DT, go to ON_HI with high = 1. If psm_r drops, go to DT_LO with cnt = 0.
  - ON_HI: high = 1. When psm_r = 0, high clears at edge E and the FSM enters DT_LO with cnt = 0.
  - DT_LO and ON_LO: mirror images of DT_HI and ON_HI.
- Outputs are registered. The old side deasserts at E. The new side asserts exactly DT cycles after E. DT = 0 gives a clean swap on the same edge, with no overlap and no gap.
- Input toggles shorter than DT never turn on the new side. The counter restarts on every psm_r change.
- DT is compared live. A DT change during a dead-time interval takes effect on the next compare.
- Invariant, all cases: oPSM[2k] & oPSM[2k+1] == 0.
- iEN low: next edge forces oPSM = 0 and all FSMs to OFF. Re-enable passes through full DT before any output asserts.
- Fault:
  - iFAULT = 1 sets oFAULT at the next edge. In that same edge oPSM goes to 0 and all FSMs go to OFF.
  - oFAULT holds until iFAULT_CLR = 1 while iFAULT = 0. If both are high in the same cycle, the fault wins.
  - After clear, channels restart from OFF and pass through full dead time.
- RST mid-operation: outputs low on the next edge, independent of state.
- Channels are fully independent apart from iEN, iFAULT and RST.

Optional Feature:
- Macro: PSM_ASYM_DT_EN.
- Defined: DT_HI uses iDT, DT_LO uses iDT_LO, giving asymmetric turn-on delays that compensate driver propagation skew.
- Undefined: both states use iDT, and iDT_LO is unconnected internally (no logic generated).

Decomposition:
- Package psm_pkg holds:
  - FSM state encoding localparams: OFF=0, DT_HI=1, ON_HI=2, DT_LO=3, ON_LO=4, 3-bit.
  - Output pair index constants: HI=0, LO=1.
- Sub-module psm_dt_channel holds one FSM, counter and output pair. The top instantiates N_CH copies in a generate loop and owns the fault latch and enable gating.

Test Plan:
- N_CH=3, iDT ch0=5. iPSM[0] 0->1 at cycle 10 -> low side low at cycle 12 (E), high side high at cycle 17; no overlap anywhere.
- iDT=0. Toggle iPSM[1] every 4 cycles -> high and low swap on the same edge, never both 1 and never both 0 after the first enable.
- iDT=10. 3-cycle high pulse on iPSM[2] -> high side stays 0 throughout; low side deasserts for 3 cycles, then reasserts after 10 more.
- iFAULT pulse mid-ON_HI -> all oPSM 0 at next edge, oFAULT=1.
  - iFAULT_CLR while iFAULT=1 -> no effect.
  - Clear after fault drops -> outputs resume only after DT cycles.
- With PSM_ASYM_DT_EN: iDT=3, iDT_LO=7 -> high turns on 3 cycles after E, low turns on 7 cycles after E.
  - Without the macro, both use 3.
- RST asserted in DT_LO with cnt=4 -> oPSM=0 next edge. After release, full DT is observed before any output asserts.

Source files
------------

// File: rtl/psm_pkg.sv
// ============================================================================
// psm_pkg : shared state encoding and helpers for the dead-time generator
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package psm_pkg;

  localparam logic [2:0] OFF   = 3'd0;
  localparam logic [2:0] DT_HI = 3'd1;
  localparam logic [2:0] ON_HI = 3'd2;
  localparam logic [2:0] DT_LO = 3'd3;
  localparam logic [2:0] ON_LO = 3'd4;

  // Bit offsets of the high/low gate inside one channel's output pair
  localparam int HI = 0;
  localparam int LO = 1;

  typedef enum logic [2:0] {
    ST_OFF   = OFF,
    ST_DT_HI = DT_HI,
    ST_ON_HI = ON_HI,
    ST_DT_LO = DT_LO,
    ST_ON_LO = ON_LO
  } state_t;

  // State to enter when a side is requested; zero dead time skips straight to ON
  function automatic state_t enter_side(input logic psm,
                                        input logic hi_zero,
                                        input logic lo_zero);
    if (psm) return hi_zero ? ST_ON_HI : ST_DT_HI;
    return lo_zero ? ST_ON_LO : ST_DT_LO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/psm_dt_channel.sv
// ============================================================================
// psm_dt_channel : one complementary gate pair with dead-time FSM and counter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module psm_dt_channel
  import psm_pkg::*;
#(
  parameter int BITS_DATA = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 iRUN,
  input  logic                 iPSM,
  input  logic [BITS_DATA-1:0] iDT_HI,
  input  logic [BITS_DATA-1:0] iDT_LO,
  output logic                 oHI,
  output logic                 oLO
);

  state_t               state_q, state_d;
  logic [BITS_DATA-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 hi_q, hi_d, lo_q, lo_d;
  logic                 hi_zero, lo_zero;

  assign hi_zero = (iDT_HI == '0);
  assign lo_zero = (iDT_LO == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    if (!iRUN) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = enter_side(iPSM, hi_zero, lo_zero);
          cnt_d   = '0;
        end
        ST_DT_HI: begin
          if (!iPSM) begin
            state_d = enter_side(1'b0, hi_zero, lo_zero);
            cnt_d   = '0;
          end else begin
            // Live compare: a dead-time change applies on the very next cycle
            cnt_d = cnt_inc;
            if (cnt_inc >= iDT_HI) state_d = ST_ON_HI;
          end
        end
        ST_ON_HI: begin
          if (!iPSM) begin
            state_d = enter_side(1'b0, hi_zero, lo_zero);
            cnt_d   = '0;
          end
        end
        ST_DT_LO: begin
          if (iPSM) begin
            state_d = enter_side(1'b1, hi_zero, lo_zero);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= iDT_LO) state_d = ST_ON_LO;
          end
        end
        ST_ON_LO: begin
          if (iPSM) begin
            state_d = enter_side(1'b1, hi_zero, lo_zero);
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    hi_d = (state_d == ST_ON_HI);
    lo_d = (state_d == ST_ON_LO);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign oHI = hi_q;
  assign oLO = lo_q;

endmodule

`default_nettype wire

// File: rtl/psm_deadtime_nch.sv
// ============================================================================
// psm_deadtime_nch : N-channel complementary gate generator with dead time,
//                    global enable and latched fault shutdown.
// Option macro     : PSM_ASYM_DT_EN (separate low-side dead time from iDT_LO)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module psm_deadtime_nch
  import psm_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int BITS_DATA = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      iEN,
  input  logic [N_CH-1:0]           iPSM,
  input  logic [N_CH*BITS_DATA-1:0] iDT,
  input  logic [N_CH*BITS_DATA-1:0] iDT_LO,
  input  logic                      iFAULT,
  input  logic                      iFAULT_CLR,
  output logic [2*N_CH-1:0]         oPSM,
  output logic                      oFAULT
);

  logic [N_CH-1:0] psm_q, psm_d;
  logic            fault_q, fault_d;
  logic            run;

  // Fault set dominates a simultaneous clear
  always_comb begin
    psm_d   = iPSM;
    fault_d = fault_q;
    if (iFAULT)          fault_d = 1'b1;
    else if (iFAULT_CLR) fault_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      psm_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      psm_q   <= psm_d;
      fault_q <= fault_d;
    end
  end

  // Raw iFAULT included so shutdown happens on the same edge the latch sets
  assign run = iEN & ~fault_q & ~iFAULT;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [BITS_DATA-1:0] dt_hi;
    logic [BITS_DATA-1:0] dt_lo;

    assign dt_hi = iDT[k*BITS_DATA +: BITS_DATA];
`ifdef PSM_ASYM_DT_EN
    assign dt_lo = iDT_LO[k*BITS_DATA +: BITS_DATA];
`else
    assign dt_lo = dt_hi;
`endif

    psm_dt_channel #(
      .BITS_DATA (BITS_DATA)
    ) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .iRUN   (run),
      .iPSM   (psm_q[k]),
      .iDT_HI (dt_hi),
      .iDT_LO (dt_lo),
      .oHI    (oPSM[2*k+HI]),
      .oLO    (oPSM[2*k+LO])
    );
  end

`ifndef PSM_ASYM_DT_EN
  logic unused_dt_lo;
  assign unused_dt_lo = ^iDT_LO;
`endif

  assign oFAULT = fault_q;

endmodule

`default_nettype wire
